// File: rtl/xbuf_host_wr_seq.sv
// Host-side write sequencer for xfer_buffer: per command, a general-setup buffer query
// followed by an N-word stream from a valid/ready source onto the host write port.
module xbuf_host_wr_seq #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter int unsigned LEN_W      = 11,
    parameter int unsigned GS_TIMEOUT = 64,
    parameter int unsigned GS_RETRY   = 4,
    parameter int unsigned BACKOFF    = 8
) (
    input  logic              clock_host,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_busy,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              gs_select,
    output logic              gs_write_enable,
    input  logic [7:0]        gs_out,
    input  logic              gs_out_enable,
    output logic              host_select,
    output logic              hwrite_enable,
    output logic [DATA_W-1:0] hostdata_out,
    output logic              hostdata_oe,
    output logic [7:0]        buf_id,
    output logic              done,
    output logic              err
);

    localparam int unsigned TMO_W = (GS_TIMEOUT > 1) ? $clog2(GS_TIMEOUT) : 1;
    localparam int unsigned RTY_W = $clog2(GS_RETRY + 1);
    localparam int unsigned BO_W  = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

    localparam logic [LEN_W-1:0] MaxLen    = LEN_W'(MAX_WORDS);
    localparam logic [TMO_W-1:0] TmoLast   = TMO_W'(GS_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RetryLast = RTY_W'(GS_RETRY - 1);
    localparam logic [BO_W-1:0]  BoLast    = BO_W'(BACKOFF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGsReq,
        StGsBackoff,
        StStream,
        StFlush,
        StDone,
        StErr
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [RTY_W-1:0]   rty_q;
    logic [BO_W-1:0]    bo_q;

    logic               beat;
    logic [LEN_W-1:0]   cnt_inc;

    always_comb begin
        beat    = src_valid && src_ready;
        cnt_inc = cnt_q + LEN_W'(1);
    end

    always_ff @(posedge clock_host or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            len_q           <= '0;
            cnt_q           <= '0;
            tmo_q           <= '0;
            rty_q           <= '0;
            bo_q            <= '0;
            cmd_busy        <= 1'b0;
            src_ready       <= 1'b0;
            gs_select       <= 1'b0;
            gs_write_enable <= 1'b0;
            host_select     <= 1'b0;
            hwrite_enable   <= 1'b0;
            hostdata_out    <= '0;
            hostdata_oe     <= 1'b0;
            buf_id          <= '0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_start) begin
                        cmd_busy <= 1'b1;
                        if (cmd_len == '0 || cmd_len > MaxLen) begin
                            err     <= 1'b1;
                            state_q <= StErr;
                        end else begin
                            len_q           <= cmd_len;
                            rty_q           <= '0;
                            tmo_q           <= '0;
                            gs_select       <= 1'b1;
                            gs_write_enable <= 1'b1;
                            state_q         <= StGsReq;
                        end
                    end
                end
                StGsReq: begin
                    if (gs_out_enable) begin
                        gs_select       <= 1'b0;
                        gs_write_enable <= 1'b0;
                        if (gs_out != 8'h00) begin
                            buf_id      <= gs_out;
                            cnt_q       <= '0;
                            host_select <= 1'b1;
                            hostdata_oe <= 1'b1;
                            src_ready   <= 1'b1;
                            state_q     <= StStream;
                        end else if (rty_q == RetryLast) begin
                            rty_q   <= rty_q + RTY_W'(1);
                            err     <= 1'b1;
                            state_q <= StErr;
                        end else begin
                            rty_q   <= rty_q + RTY_W'(1);
                            bo_q    <= '0;
                            state_q <= StGsBackoff;
                        end
                    end else if (tmo_q == TmoLast) begin
                        gs_select       <= 1'b0;
                        gs_write_enable <= 1'b0;
                        err             <= 1'b1;
                        state_q         <= StErr;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                StGsBackoff: begin
                    if (bo_q == BoLast) begin
                        tmo_q           <= '0;
                        gs_select       <= 1'b1;
                        gs_write_enable <= 1'b1;
                        state_q         <= StGsReq;
                    end else begin
                        bo_q <= bo_q + BO_W'(1);
                    end
                end
                StStream: begin
                    // Registered write port: a beat at this edge is presented next cycle.
                    hwrite_enable <= beat;
                    if (beat) begin
                        hostdata_out <= src_data;
                        cnt_q        <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            src_ready <= 1'b0;
                            state_q   <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    host_select   <= 1'b0;
                    hwrite_enable <= 1'b0;
                    hostdata_oe   <= 1'b0;
                    done          <= 1'b1;
                    state_q       <= StDone;
                end
                StDone: begin
                    cmd_busy <= 1'b0;
                    state_q  <= StIdle;
                end
                StErr: begin
                    cmd_busy <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    cmd_busy        <= 1'b0;
                    src_ready       <= 1'b0;
                    gs_select       <= 1'b0;
                    gs_write_enable <= 1'b0;
                    host_select     <= 1'b0;
                    hwrite_enable   <= 1'b0;
                    hostdata_oe     <= 1'b0;
                    state_q         <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbuf_host_wr_seq.sv
// Self-checking bench for xbuf_host_wr_seq: table of commands plus reset corner cases,
// with a write-data scoreboard fed by accepted source beats.
module tb_xbuf_host_wr_seq;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LEN_W   = 11;
    localparam int unsigned BACKOFF = 8;

    logic              clock_host = 1'b0;
    logic              reset;
    logic              cmd_start;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_busy;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              gs_select;
    logic              gs_write_enable;
    logic [7:0]        gs_out;
    logic              gs_out_enable;
    logic              host_select;
    logic              hwrite_enable;
    logic [DATA_W-1:0] hostdata_out;
    logic              hostdata_oe;
    logic [7:0]        buf_id;
    logic              done;
    logic              err;

    xbuf_host_wr_seq dut (
        .clock_host      (clock_host),
        .reset           (reset),
        .cmd_start       (cmd_start),
        .cmd_len         (cmd_len),
        .cmd_busy        (cmd_busy),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .gs_select       (gs_select),
        .gs_write_enable (gs_write_enable),
        .gs_out          (gs_out),
        .gs_out_enable   (gs_out_enable),
        .host_select     (host_select),
        .hwrite_enable   (hwrite_enable),
        .hostdata_out    (hostdata_out),
        .hostdata_oe     (hostdata_oe),
        .buf_id          (buf_id),
        .done            (done),
        .err             (err)
    );

    always #5 clock_host = ~clock_host;

    typedef struct {
        int unsigned len;
        int          mode;       // 0 idle source, 1 valid stuck high, 2 valid toggling
        int          zeros;      // setup replies of 0 before the final one
        bit          fin;        // send a nonzero final reply
        logic [7:0]  resp;
        int          delay;      // cycles between seeing gs_select and replying
        bit          poke;       // pulse cmd_start while busy
        int          exp_writes;
        int          exp_done;
        int          exp_err;
        logic [7:0]  exp_buf;
        int          exp_ep;
        int          exp_hi;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    logic [DATA_W-1:0] exp_q[$];
    int   src_mode  = 0;
    int   word_idx  = 0;
    bit   beat_seen = 1'b0;

    int   cyc = 0;
    int   wr_cnt, done_cnt, err_cnt, gs_ep, gs_hi, last_wr_cyc, gs_last_hi;
    bit   wrote_any, gs_prev = 1'b0;
    logic [DATA_W-1:0] last_data;
    logic [DATA_W-1:0] exp_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({cmd_busy, src_ready, gs_select, gs_write_enable, host_select, hwrite_enable,
                    hostdata_out, hostdata_oe, buf_id, done, err});
    endfunction

    // Source: present word_idx as data; a beat sampled at the negedge is pushed to the scoreboard.
    always @(posedge clock_host) begin
        #1;
        if (beat_seen) begin
            exp_q.push_back(src_data);
            word_idx++;
        end
        beat_seen = 1'b0;
        case (src_mode)
            1:       src_valid = 1'b1;
            2:       src_valid = !src_valid;
            default: src_valid = 1'b0;
        endcase
        src_data = DATA_W'(word_idx);
    end

    always @(negedge clock_host) begin
        cyc++;
        beat_seen = src_valid && src_ready;
        if (!reset) begin
            if (hwrite_enable) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                check("write_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    check("write_data", 64'(hostdata_out), 64'(exp_d));
                end
                check("write_port", 64'({host_select, hostdata_oe}), 64'd3);
                last_data = hostdata_out;
                wrote_any = 1'b1;
            end else if (host_select && wrote_any) begin
                check("gap_hold", 64'(hostdata_out), 64'(last_data));
            end
            if (done) begin
                done_cnt++;
                check("done_after_last", 64'(cyc - last_wr_cyc), 64'd1);
            end
            if (err) err_cnt++;
            if (gs_select) begin
                if (!gs_prev) begin
                    if (gs_ep > 0) check("backoff_gap", 64'(cyc - gs_last_hi - 1), 64'(BACKOFF));
                    gs_ep++;
                end
                gs_hi++;
                gs_last_hi = cyc;
                check("gs_we", 64'(gs_write_enable), 64'd1);
            end
        end
        gs_prev = gs_select;
    end

    task automatic clear_trk();
        wr_cnt = 0; done_cnt = 0; err_cnt = 0; gs_ep = 0; gs_hi = 0;
        last_wr_cyc = 0; wrote_any = 1'b0; word_idx = 0;
        exp_q.delete();
    endtask

    task automatic start_cmd(input int unsigned len, input int mode);
        @(posedge clock_host); #1;
        cmd_len   = LEN_W'(len);
        cmd_start = 1'b1;
        src_mode  = mode;
        @(posedge clock_host); #1;
        cmd_start = 1'b0;
    endtask

    task automatic respond(input int zeros, input bit fin, input logic [7:0] resp,
                           input int delay);
        int total;
        int n;
        total = zeros + (fin ? 1 : 0);
        for (int a = 0; a < total; a++) begin
            n = 0;
            do begin
                @(negedge clock_host);
                n++;
            end while (!gs_select && n < 200);
            if (!gs_select) begin
                check("gs_request_seen", 64'(gs_select), 64'd1);
                return;
            end
            repeat (delay) @(posedge clock_host);
            #1;
            gs_out        = (a < zeros) ? 8'h00 : resp;
            gs_out_enable = 1'b1;
            @(posedge clock_host); #1;
            gs_out_enable = 1'b0;
            gs_out        = 8'h00;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock_host);
            n++;
        end while (cmd_busy && n < budget);
        check("busy_clears", 64'(cmd_busy), 64'd0);
        repeat (2) @(negedge clock_host);
    endtask

    task automatic run_cmd(input vec_t v);
        clear_trk();
        start_cmd(v.len, v.mode);
        respond(v.zeros, v.fin, v.resp, v.delay);
        if (v.poke) begin
            @(posedge clock_host); #1;
            cmd_len   = LEN_W'(1);
            cmd_start = 1'b1;
            @(posedge clock_host); #1;
            cmd_start = 1'b0;
        end
        wait_idle(int'(v.len) * 3 + 300);
        src_mode = 0;
        check("write_count", 64'(wr_cnt), 64'(v.exp_writes));
        check("done_count", 64'(done_cnt), 64'(v.exp_done));
        check("err_count", 64'(err_cnt), 64'(v.exp_err));
        check("buf_id", 64'(buf_id), 64'(v.exp_buf));
        check("gs_episodes", 64'(gs_ep), 64'(v.exp_ep));
        check("gs_high_cycles", 64'(gs_hi), 64'(v.exp_hi));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    vec_t vecs[9];
    vec_t tail;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_start = 1'b0; cmd_len = '0; src_valid = 1'b0; src_data = '0;
        gs_out = 8'h00; gs_out_enable = 1'b0;
        clear_trk();

        vecs[0] = '{1024, 1, 0, 1'b1, 8'h01, 3, 1'b0, 1024, 1, 0, 8'h01, 1, 4};
        vecs[1] = '{4,    2, 0, 1'b1, 8'h3c, 0, 1'b1, 4,    1, 0, 8'h3c, 1, 1};
        vecs[2] = '{3,    1, 2, 1'b1, 8'h05, 1, 1'b0, 3,    1, 0, 8'h05, 3, 6};
        vecs[3] = '{0,    1, 0, 1'b0, 8'h00, 0, 1'b0, 0,    0, 1, 8'h05, 0, 0};
        vecs[4] = '{1025, 1, 0, 1'b0, 8'h00, 0, 1'b0, 0,    0, 1, 8'h05, 0, 0};
        vecs[5] = '{2,    1, 4, 1'b0, 8'h00, 1, 1'b0, 0,    0, 1, 8'h05, 4, 8};
        vecs[6] = '{5,    1, 0, 1'b0, 8'h00, 0, 1'b0, 0,    0, 1, 8'h05, 1, 64};
        vecs[7] = '{1,    1, 0, 1'b1, 8'hff, 2, 1'b0, 1,    1, 0, 8'hff, 1, 3};
        vecs[8] = '{7,    2, 1, 1'b1, 8'h80, 0, 1'b0, 7,    1, 0, 8'h80, 2, 2};

        // Reset and idle
        repeat (2) @(posedge clock_host);
        @(negedge clock_host);
        check("reset_outputs", all_outs(), 64'd0);
        @(posedge clock_host); #1;
        reset = 1'b0;
        repeat (5) @(negedge clock_host);
        check("idle_outputs", all_outs(), 64'd0);
        check("idle_busy", 64'(cmd_busy), 64'd0);

        foreach (vecs[i]) run_cmd(vecs[i]);

        // Asynchronous reset in the middle of a 16-word stream
        clear_trk();
        start_cmd(16, 1);
        respond(0, 1'b1, 8'h22, 0);
        for (int n = 0; n < 200; n++) begin
            @(negedge clock_host); #1;
            if (wr_cnt >= 10) break;
        end
        check("midop_progress", 64'(wr_cnt >= 10), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midop_reset_outputs", all_outs(), 64'd0);
        src_mode = 0;
        repeat (2) @(posedge clock_host);
        #1;
        reset = 1'b0;
        @(negedge clock_host);
        check("post_reset_outputs", all_outs(), 64'd0);

        tail = '{2, 1, 0, 1'b1, 8'h33, 0, 1'b0, 2, 1, 0, 8'h33, 1, 1};
        run_cmd(tail);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
